// File: rtl/cpu_run_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_controller_pkg
//  Purpose  : Shared definitions for the CPU run controller. Holds the
//             controller state encoding, the default dump section lengths,
//             the dump_is_mem beat-type encodings and the dump index width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cpu_run_controller_pkg;

   // Controller states, 3-bit encoded.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RUN      = 3'd1,
      S_DUMP_REG = 3'd2,
      S_DUMP_MEM = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   // Default dump section lengths.
   localparam int c_NUM_REGS_DEF  = 32;
   localparam int c_MEM_WORDS_DEF = 64;

   // Beat-type encodings carried on dump_is_mem.
   localparam logic c_BEAT_REG = 1'b0;
   localparam logic c_BEAT_MEM = 1'b1;

   // Width of the dump beat index (matches the dump_index port).
   localparam int c_IDX_W = 7;

   // Last valid index of a section holding n beats.
   function automatic logic [c_IDX_W-1:0] last_idx(input int n);
      return c_IDX_W'(n - 1);
   endfunction

endpackage : cpu_run_controller_pkg
`default_nettype wire

// File: rtl/cpu_run_controller_dump_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_controller_dump_sequencer
//  Purpose  : Beat index counter for the state dump. Advances on each
//             valid/ready transfer and wraps to zero after the last beat of
//             the current section, so the next section starts at index 0.
//  Ports    : clk, rst_n      clock / async active-low reset
//             i_clear         force index to 0 (new run accepted)
//             i_advance       a beat was transferred this cycle
//             i_last_idx      last index of the current section
//             o_index         current beat index
//             o_last          current beat is the last of the section
//  Revision : 1.0  initial release
// ============================================================================
module cpu_run_controller_dump_sequencer
   import cpu_run_controller_pkg::*;
#(
   parameter int IDX_W = c_IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_advance,
   input  logic [IDX_W-1:0] i_last_idx,
   output logic [IDX_W-1:0] o_index,
   output logic             o_last
);

   logic [IDX_W-1:0] r_index;

   assign o_last  = (r_index == i_last_idx);
   assign o_index = r_index;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_index <= '0;
      end else if (i_clear) begin
         r_index <= '0;
      end else if (i_advance) begin
         // Wrapping on the last beat hands the next section a clean index.
         r_index <= o_last ? '0 : r_index + 1'b1;
      end
   end

endmodule : cpu_run_controller_dump_sequencer
`default_nettype wire

// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_controller
//  Purpose  : Sequences a single-cycle MIPS datapath. Runs the CPU for a
//             bounded number of clocks (or until a PC self-loop is seen),
//             then halts it and streams all registers followed by the
//             data-memory words over a valid/ready port.
//  Ports    : clk, rst_n              clock / async active-low reset
//             i_start, i_max_cycles   run request and cycle budget
//             i_pc, i_pc_new          current / next PC from the CPU
//             o_cpu_en                CPU may advance PC and write state
//             o_dbg_reg_sel/_a        register read-port override
//             i_dbg_reg_rd            register read data
//             o_dbg_mem_sel/_a        data-memory address override
//             i_dbg_mem_rd            data-memory read data
//             o_dump_*/i_dump_ready   dump stream (valid/ready)
//             o_busy, o_done          run / dump status
//             o_halted_early          last run ended on PC self-loop
//             o_cycle_count           enabled cycles of last/current run
//  Revision : 1.0  initial release
// ============================================================================
module cpu_run_controller
   import cpu_run_controller_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int NUM_REGS    = c_NUM_REGS_DEF,
   parameter int MEM_WORDS   = c_MEM_WORDS_DEF,
   parameter int HALT_DETECT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_max_cycles,
   input  logic [31:0]      i_pc,
   input  logic [31:0]      i_pc_new,
   output logic             o_cpu_en,
   output logic             o_dbg_reg_sel,
   output logic [4:0]       o_dbg_reg_a,
   input  logic [31:0]      i_dbg_reg_rd,
   output logic             o_dbg_mem_sel,
   output logic [31:0]      o_dbg_mem_a,
   input  logic [31:0]      i_dbg_mem_rd,
   output logic             o_dump_valid,
   input  logic             i_dump_ready,
   output logic             o_dump_is_mem,
   output logic [6:0]       o_dump_index,
   output logic [31:0]      o_dump_data,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_halted_early,
   output logic [CNT_W-1:0] o_cycle_count
);

   state_t               r_state;
   state_t               w_next_state;
   logic [CNT_W-1:0]     r_budget;
   logic [CNT_W-1:0]     r_cycle_count;
   logic                 r_halted_early;

   logic                 w_start_ok;
   logic                 w_transfer;
   logic [CNT_W:0]       w_cnt_plus1;
   logic                 w_budget_hit;
   logic                 w_halt_hit;
   logic                 w_cnt_sat;
   logic [c_IDX_W-1:0]   w_index;
   logic [c_IDX_W-1:0]   w_last_idx;
   logic                 w_last;

   // ------------------------------------------------------------------------
   // Condition decode
   // ------------------------------------------------------------------------
   assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_transfer = o_dump_valid && i_dump_ready;

   // One extra bit so the compare is exact even when the count is all-ones.
   assign w_cnt_plus1  = {1'b0, r_cycle_count} + {{CNT_W{1'b0}}, 1'b1};
   assign w_budget_hit = (w_cnt_plus1 == {1'b0, r_budget});
   assign w_halt_hit   = (HALT_DETECT != 0) && (i_pc_new == i_pc);
   assign w_cnt_sat    = &r_cycle_count;

   // Section length follows the state; DUMP_REG is also the value used while
   // idle, which is harmless because the index only advances on transfers.
   assign w_last_idx = (r_state == S_DUMP_MEM) ? last_idx(MEM_WORDS)
                                               : last_idx(NUM_REGS);

   // ------------------------------------------------------------------------
   // Dump beat index
   // ------------------------------------------------------------------------
   cpu_run_controller_dump_sequencer #(
      .IDX_W (c_IDX_W)
   ) u_dump_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_start_ok),
      .i_advance  (w_transfer),
      .i_last_idx (w_last_idx),
      .o_index    (w_index),
      .o_last     (w_last)
   );

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_start_ok) begin
               w_next_state = (i_max_cycles == '0) ? S_DUMP_REG : S_RUN;
            end
         end
         S_RUN: begin
            if (w_budget_hit || w_halt_hit) begin
               w_next_state = S_DUMP_REG;
            end
         end
         S_DUMP_REG: begin
            if (w_transfer && w_last) begin
               w_next_state = S_DUMP_MEM;
            end
         end
         S_DUMP_MEM: begin
            if (w_transfer && w_last) begin
               w_next_state = S_DONE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Run bookkeeping: budget, cycle counter, halt flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_budget       <= '0;
         r_cycle_count  <= '0;
         r_halted_early <= 1'b0;
      end else if (w_start_ok) begin
         r_budget       <= i_max_cycles;
         r_cycle_count  <= '0;
         r_halted_early <= 1'b0;
      end else if (r_state == S_RUN) begin
         if (!w_cnt_sat) begin
            r_cycle_count <= r_cycle_count + 1'b1;
         end
         // Halt detect wins when it coincides with the budget edge.
         if (w_halt_hit) begin
            r_halted_early <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Moore output decode
   // ------------------------------------------------------------------------
   always_comb begin
      o_cpu_en      = 1'b0;
      o_dbg_reg_sel = 1'b0;
      o_dbg_reg_a   = 5'd0;
      o_dbg_mem_sel = 1'b0;
      o_dbg_mem_a   = 32'd0;
      o_dump_valid  = 1'b0;
      o_dump_is_mem = c_BEAT_REG;
      o_dump_index  = 7'd0;
      o_dump_data   = 32'd0;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      case (r_state)
         S_RUN: begin
            o_cpu_en = 1'b1;
            o_busy   = 1'b1;
         end
         S_DUMP_REG: begin
            o_dbg_reg_sel = 1'b1;
            o_dbg_reg_a   = w_index[4:0];
            o_dump_valid  = 1'b1;
            o_dump_is_mem = c_BEAT_REG;
            o_dump_index  = w_index;
            o_dump_data   = i_dbg_reg_rd;
            o_busy        = 1'b1;
         end
         S_DUMP_MEM: begin
            o_dbg_mem_sel = 1'b1;
            o_dbg_mem_a   = {{(32-c_IDX_W-2){1'b0}}, w_index, 2'b00};
            o_dump_valid  = 1'b1;
            o_dump_is_mem = c_BEAT_MEM;
            o_dump_index  = w_index;
            o_dump_data   = i_dbg_mem_rd;
            o_busy        = 1'b1;
         end
         S_DONE: begin
            o_done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign o_halted_early = r_halted_early;
   assign o_cycle_count  = r_cycle_count;

endmodule : cpu_run_controller
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_run_controller
//  Purpose  : Self-checking bench for cpu_run_controller. Provides a register
//             file / data memory image, a PC that steps by 4 while enabled
//             (optionally self-looping on a chosen enabled cycle), and checks
//             each run's length, halt flag and full dump stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_run_controller;

   localparam int CNT_W = 32;
   localparam int NREG  = 32;
   localparam int NMEM  = 64;
   localparam int NBEAT = NREG + NMEM;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CNT_W-1:0] max_cycles;
   logic [31:0]      pc = 32'h0040_0000;
   logic [31:0]      pc_new;
   logic             cpu_en;
   logic             dbg_reg_sel;
   logic [4:0]       dbg_reg_a;
   logic [31:0]      dbg_reg_rd;
   logic             dbg_mem_sel;
   logic [31:0]      dbg_mem_a;
   logic [31:0]      dbg_mem_rd;
   logic             dump_valid;
   logic             dump_ready;
   logic             dump_is_mem;
   logic [6:0]       dump_index;
   logic [31:0]      dump_data;
   logic             busy;
   logic             done;
   logic             halted_early;
   logic [CNT_W-1:0] cycle_count;

   logic [31:0] regs [NREG];
   logic [31:0] mem  [NMEM];

   int en_cnt  = 0;   // enabled clocks since time zero
   int base    = 0;   // en_cnt at the start of the current run
   int halt_at = 0;   // enabled cycle (1-based) on which PC self-loops; 0 = never

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cpu_run_controller #(
      .CNT_W       (CNT_W),
      .NUM_REGS    (NREG),
      .MEM_WORDS   (NMEM),
      .HALT_DETECT (1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (start),
      .i_max_cycles   (max_cycles),
      .i_pc           (pc),
      .i_pc_new       (pc_new),
      .o_cpu_en       (cpu_en),
      .o_dbg_reg_sel  (dbg_reg_sel),
      .o_dbg_reg_a    (dbg_reg_a),
      .i_dbg_reg_rd   (dbg_reg_rd),
      .o_dbg_mem_sel  (dbg_mem_sel),
      .o_dbg_mem_a    (dbg_mem_a),
      .i_dbg_mem_rd   (dbg_mem_rd),
      .o_dump_valid   (dump_valid),
      .i_dump_ready   (dump_ready),
      .o_dump_is_mem  (dump_is_mem),
      .o_dump_index   (dump_index),
      .o_dump_data    (dump_data),
      .o_busy         (busy),
      .o_done         (done),
      .o_halted_early (halted_early),
      .o_cycle_count  (cycle_count)
   );

   // Environment: combinational register file / memory reads, simple PC.
   assign dbg_reg_rd = regs[dbg_reg_a];
   assign dbg_mem_rd = mem[dbg_mem_a[7:2]];
   assign pc_new = (halt_at != 0 && (en_cnt - base) == halt_at - 1) ? pc : pc + 32'd4;

   always @(posedge clk) begin
      if (cpu_en) begin
         pc     <= pc_new;
         en_cnt <= en_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: run length and halt flag from budget and halt cycle.
   function automatic void model(input int budget, input int h, output int cyc, output bit hl);
      if (budget == 0) begin
         cyc = 0; hl = 1'b0;
      end else if (h != 0 && h <= budget) begin
         cyc = h; hl = 1'b1;
      end else begin
         cyc = budget; hl = 1'b0;
      end
   endfunction

   // Whether the currently presented beat matches expected beat k.
   function automatic bit beat_ok(input int k);
      bit          m;
      int          idx;
      logic [31:0] d;
      m   = (k >= NREG);
      idx = m ? k - NREG : k;
      d   = m ? mem[idx] : regs[idx];
      if (k >= NBEAT) return 1'b0;
      if (dump_is_mem !== m || int'(dump_index) != idx || dump_data !== d || busy !== 1'b1)
         return 1'b0;
      if (m) return dbg_mem_sel === 1'b1 && dbg_mem_a == 32'(idx * 4);
      return dbg_reg_sel === 1'b1 && int'(dbg_reg_a) == idx;
   endfunction

   // Full run: start, observe run length, consume the dump with random
   // backpressure, and compare everything against the expected values.
   task automatic run_case(input int budget, input int h, input int rdy_pct,
                           input int exp_cyc, input bit exp_h, input string tag);
      int k = 0, en_seen = 0, bad = 0, excl = 0, t = 0, first_bad = -1;
      bit fin = 1'b0;
      @(negedge clk);
      halt_at = h; base = en_cnt; max_cycles = CNT_W'(budget);
      start = 1'b1; dump_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (!fin && t < 5000) begin
         if (int'(cpu_en) + int'(dbg_reg_sel) + int'(dbg_mem_sel) > 1) excl++;
         if (cpu_en) en_seen++;
         if (done) begin
            fin = 1'b1;
         end else begin
            if (dump_valid && !beat_ok(k)) begin
               bad++;
               if (first_bad < 0) first_bad = k;
            end
            dump_ready = ($urandom_range(99) < rdy_pct);
            if (dump_valid && dump_ready) k++;
            @(negedge clk);
            t++;
         end
      end
      if (first_bad >= 0) $display("FAIL %s: first bad beat %0d", tag, first_bad);
      chk({tag, " done"}, fin, 1);
      chk({tag, " busy after done"}, busy, 0);
      chk({tag, " cpu_en clocks"}, en_seen, exp_cyc);
      chk({tag, " cycle_count"}, cycle_count, exp_cyc);
      chk({tag, " halted_early"}, halted_early, exp_h);
      chk({tag, " beats"}, k, NBEAT);
      chk({tag, " stream errors"}, bad, 0);
      chk({tag, " exclusivity"}, excl, 0);
   endtask

   // Bounded wait until the given beat is presented; ready held as set.
   task automatic wait_beat(input bit m, input int idx, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         if (dump_valid && dump_is_mem == m && int'(dump_index) == idx) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   // Drain the stream with ready high; reports cpu_en sightings.
   task automatic drain(output bit ok, output int en_seen);
      ok = 1'b0; en_seen = 0; dump_ready = 1'b1;
      for (int i = 0; i < 3000 && !ok; i++) begin
         if (cpu_en) en_seen++;
         if (done) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   typedef struct {
      int budget;
      int halt;
      int exp_cyc;
      bit exp_halt;
   } vec_t;

   initial begin
      vec_t vecs[7];
      bit   ok;
      int   en_seen, cyc, b, h, r;
      bit   hl;
      logic [31:0] rdata;

      for (int i = 0; i < NREG; i++) regs[i] = $urandom;
      for (int i = 0; i < NMEM; i++) mem[i]  = $urandom;

      vecs[0] = '{budget: 5,   halt: 0, exp_cyc: 5, exp_halt: 1'b0};
      vecs[1] = '{budget: 100, halt: 3, exp_cyc: 3, exp_halt: 1'b1};
      vecs[2] = '{budget: 1,   halt: 0, exp_cyc: 1, exp_halt: 1'b0};
      vecs[3] = '{budget: 1,   halt: 1, exp_cyc: 1, exp_halt: 1'b1};
      vecs[4] = '{budget: 4,   halt: 4, exp_cyc: 4, exp_halt: 1'b1};
      vecs[5] = '{budget: 3,   halt: 7, exp_cyc: 3, exp_halt: 1'b0};
      vecs[6] = '{budget: 0,   halt: 0, exp_cyc: 0, exp_halt: 1'b0};

      // ---- Reset with random inputs and start asserted -------------------
      rst_n = 1'b0; start = 1'b1; max_cycles = $urandom; dump_ready = 1'(($urandom));
      repeat (2) @(negedge clk);
      chk("reset outputs",
          {cpu_en, dbg_reg_sel, dbg_reg_a, dbg_mem_sel, dbg_mem_a, dump_valid, dump_is_mem,
           dump_index, busy, done, halted_early}, 64'd0);
      chk("reset cycle_count", cycle_count, 0);
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("idle after reset", {busy, done, cpu_en, dump_valid}, 0);

      // ---- Table-driven runs (full ready) --------------------------------
      foreach (vecs[i])
         run_case(vecs[i].budget, vecs[i].halt, 100, vecs[i].exp_cyc, vecs[i].exp_halt,
                  $sformatf("vec%0d", i));

      // ---- Backpressure at register index 7 ------------------------------
      @(negedge clk);
      halt_at = 0; base = en_cnt; max_cycles = 2; start = 1'b1; dump_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_beat(1'b0, 7, ok);
      chk("bp reach idx7", ok, 1);
      dump_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rdata = regs[7];
         chk($sformatf("bp hold %0d", i),
             {dump_valid, dump_index, dbg_reg_a, dump_data}, {1'b1, 7'd7, 5'd7, rdata});
         @(negedge clk);
      end
      dump_ready = 1'b1;
      @(negedge clk);
      chk("bp advance idx8", {dump_is_mem, dump_index}, {1'b0, 7'd8});
      drain(ok, en_seen);
      chk("bp done", ok, 1);

      // ---- Zero budget, then start while in DUMP_MEM ---------------------
      @(negedge clk);
      halt_at = 0; base = en_cnt; max_cycles = 0; start = 1'b1; dump_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("zero dump at once", {cpu_en, dump_valid, dump_is_mem, dump_index}, {1'b0, 1'b1, 1'b0, 7'd0});
      chk("zero cycle_count", cycle_count, 0);
      dump_ready = 1'b1;
      wait_beat(1'b1, 5, ok);
      chk("zero reach mem5", ok, 1);
      start = 1'b1; max_cycles = 50;
      @(negedge clk);
      start = 1'b0;
      chk("busy start ignored", {busy, dump_is_mem, dump_index}, {1'b1, 1'b1, 7'd6});
      drain(ok, en_seen);
      chk("zero done", ok, 1);
      chk("zero never enabled", en_seen, 0);
      chk("zero final count", cycle_count, 0);

      // ---- Async reset in DUMP_MEM at index 20, then fresh run -----------
      @(negedge clk);
      halt_at = 0; base = en_cnt; max_cycles = 3; start = 1'b1; dump_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_beat(1'b1, 20, ok);
      chk("areset reach mem20", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("areset immediate", {busy, dump_valid, dbg_mem_sel, cpu_en, dump_index}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_case(6, 2, 70, 2, 1'b1, "after areset");

      // ---- Randomized runs against the reference model -------------------
      for (int n = 0; n < 8; n++) begin
         b = $urandom_range(0, 20);
         h = $urandom_range(0, 25);
         r = $urandom_range(30, 100);
         model(b, h, cyc, hl);
         run_case(b, h, r, cyc, hl, $sformatf("rand%0d b=%0d h=%0d", n, b, h));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_cpu_run_controller
`default_nettype wire

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the single-cycle MIPS datapath: runs the CPU for a bounded number of clocks, then halts it and streams out architectural state.
- Streams all 32 registers, then MEM_WORDS data-memory words, over a valid/ready port.
- Sits beside mips_cpu and owns three things: the CPU enable (gating PC update, register we3 and data-memory we), a debug override of register read port a1, and a debug override of the data-memory address.

Parameters:
CNT_W, 32, width of cycle budget and cycle counter
NUM_REGS, 32, registers dumped (index 0..NUM_REGS-1)
MEM_WORDS, 64, data-memory words dumped (byte addr = index*4)
HALT_DETECT, 1, 1 = stop early when pc_new == pc (self-loop halt)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
start  in  1  one-cycle pulse; accepted only in IDLE or DONE
max_cycles  in  CNT_W  cycle budget, sampled on accepted start
pc  in  32  current PC (d_flop q)
pc_new  in  32  next PC from mips_cpu
cpu_en  out  1  high = CPU may advance PC and write reg/mem
dbg_reg_sel  out  1  high = register port a1 driven by dbg_reg_a
dbg_reg_a  out  5  register index during dump
dbg_reg_rd  in  32  register rd1 (combinational read)
dbg_mem_sel  out  1  high = data-memory address driven by dbg_mem_a
dbg_mem_a  out  32  byte address during dump
dbg_mem_rd  in  32  data-memory rd (combinational read)
dump_valid  out  1  dump beat available
dump_ready  in  1  consumer accepts beat
dump_is_mem  out  1  0 = register beat, 1 = memory beat
dump_index  out  7  beat index within current section
dump_data  out  32  beat payload
busy  out  1  high in RUN, DUMP_REG, DUMP_MEM
done  out  1  high in DONE
halted_early  out  1  run ended by halt detect, not by budget
cycle_count  out  CNT_W  CPU-enabled cycles executed in last or current run

Behaviour:
- States: IDLE, RUN, DUMP_REG, DUMP_MEM, DONE. All outputs are Moore, decoded from registered state/index; dump_data is muxed combinationally from dbg_reg_rd or dbg_mem_rd.
- Reset (async, rst_n=0): state IDLE; every output 0; cycle_count 0; halted_early 0; internal budget and index 0. Takes effect immediately, including mid-run or mid-dump; cpu_en drops in the same instant. PC reset is outside this block.
- IDLE/DONE + start: latch budget = max_cycles; clear cycle_count, halted_early and index.
  - If budget == 0, next state is DUMP_REG.
  - Otherwise next state is RUN.
  - start is ignored in every other state.
- RUN: cpu_en=1. Each clock increments cycle_count. Leave RUN after the edge on which either:
  - cycle_count+1 == budget → DUMP_REG, halted_early=0; or
  - HALT_DETECT && pc_new == pc → DUMP_REG, halted_early=1. The halting cycle is counted.
  - If both hold on the same edge, halted_early=1.
  - cycle_count saturates at all-ones and never wraps.
- DUMP_REG: dbg_reg_sel=1, dbg_reg_a=index[4:0], dump_valid=1, dump_is_mem=0, dump_data=dbg_reg_rd.
  - Transfer = dump_valid && dump_ready. On transfer, index++.
  - On transfer at index NUM_REGS-1: index←0, go to DUMP_MEM.
- DUMP_MEM: dbg_mem_sel=1, dbg_mem_a=index*4, dump_is_mem=1, dump_data=dbg_mem_rd.
  - On transfer at index MEM_WORDS-1: go to DONE.
- Backpressure: while dump_valid && !dump_ready, dump_index, dbg_*_a and state stay constant. dump_data is stable because reads are combinational and the CPU is disabled.
- dump_valid never drops without a transfer except on reset.
- DONE: done=1, cpu_en=0. cycle_count and halted_early hold until the next accepted start.
- Invariant: cpu_en, dbg_reg_sel and dbg_mem_sel are mutually exclusive. The CPU never writes state during a dump.

Decomposition:
- Shared include cpu_ctrl_defs.vh holds:
  - state encodings (3-bit localparams S_IDLE..S_DONE);
  - NUM_REGS and MEM_WORDS defaults;
  - the dump_is_mem encodings.
- One natural sub-module, dump_sequencer: the index counter with handshake advance and last-beat flag, instantiated once. The section length is selected by state.

Test Plan:
- Reset: rst_n low for 2 cycles, inputs random → all outputs 0, state IDLE; start while rst_n=0 ignored.
- Budget run: pc increments by 4, start with max_cycles=5, dump_ready=1 → cpu_en high exactly 5 clocks, then cycle_count=5, halted_early=0, 32 register beats (indices 0..31), 64 memory beats (dbg_mem_a 0..252), then done=1.
- Halt detect: max_cycles=100, pc_new==pc on 3rd enabled cycle → cpu_en high 3 clocks, cycle_count=3, halted_early=1, dump follows.
- Backpressure: dump_ready=0 for 4 clocks while at register index 7 → dump_index=7, dbg_reg_a=7, dump_data=reg[7] held; index 8 only after ready returns.
- Zero budget and start-while-busy: max_cycles=0 → cpu_en never high, dump begins the next cycle, cycle_count=0; a start pulse during DUMP_MEM has no effect.
- Async reset mid DUMP_MEM at index 20 → busy, dump_valid, dbg_mem_sel go 0 immediately; a new start then runs a full fresh sequence from register index 0.
